alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width; shift amount is SrcB[4:0].
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  command valid from issue stage.
REQ-005 in_ready  output  1  unit can accept a command.
REQ-006 Operation  input  4  ALU operation code from the ALU controller.
REQ-007 SrcA  input  DATA_W  first operand.
REQ-008 SrcB  input  DATA_W  second operand / shift amount source.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 ALUResult  output  DATA_W  result word.
REQ-012 Branch  output  1  comparison/branch-taken flag.
REQ-013 Illegal  output  1  Operation code unassigned.

Function
REQ-014 Opcodes SHALL decode as: 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 XOR, 1000 BEQ, 1001 BNE, 1010 BLT, 1011 BGE, 1100 SLL, 1101 SRL, 1110 SLT, 1111 SRA.
REQ-015 Codes 0101, 0110, 0111 SHALL complete in single-cycle timing with ALUResult=0, Branch=0, Illegal=1.
REQ-016 FSM SHALL have states IDLE, SHIFT, DONE; in_ready=1 only in IDLE.
REQ-017 Accept SHALL occur on an edge with in_valid=1 and in_ready=1; Operation, SrcA, SrcB captured into registers at that edge; inputs ignored otherwise.
REQ-018 Non-shift ops (and shifts with SrcB[4:0]=0): IDLE->DONE at accept edge; out_valid=1 one cycle after accept.
REQ-019 Shifts with n=SrcB[4:0]>0: IDLE->SHIFT at accept; 5-bit counter loaded with n; one bit position shifted per cycle; counter decrements; SHIFT->DONE on edge where counter=1; out_valid asserted n+1 cycles after accept.
REQ-020 SRA SHALL replicate bit DATA_W-1 of SrcA; SRL/SLL fill zeros.
REQ-021 ADD/SUB SHALL be modulo 2^DATA_W, overflow discarded, no carry output.
REQ-022 BLT, BGE, SLT SHALL compare signed; BEQ/BNE on equality.
REQ-023 Branch ops: Branch=taken, ALUResult={0..,taken}; SLT: ALUResult={0..,SrcA<SrcB}, Branch=0; all other ops Branch=0.
REQ-024 In DONE: out_valid=1, ALUResult/Branch/Illegal held stable until out_ready=1; DONE->IDLE on edge with out_ready=1.
REQ-025 No accept in the DONE->IDLE cycle; minimum issue interval is 2 cycles (back-to-back accept disallowed since in_ready=0 in DONE).
REQ-026 out_valid SHALL be 0 in IDLE and SHIFT; ALUResult, Branch, Illegal SHALL be 0 whenever out_valid=0.
REQ-027 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-028 reset=1 SHALL immediately force IDLE, counter=0, out_valid=0, ALUResult=0, Branch=0, Illegal=0, in_ready=1 (after reset released, in_ready=1).
REQ-029 Reset asserted in SHIFT or DONE SHALL abort the operation; result discarded, no out_valid pulse after release.
REQ-030 First accept permitted on first rising edge with reset=0.

Verification
REQ-031 ADD SrcA=0x7FFFFFFF, SrcB=1, out_ready=1 -> out_valid one cycle after accept, ALUResult=0x80000000, Branch=0, Illegal=0.
REQ-032 SRA SrcA=0x80000000, SrcB=31 -> out_valid 32 cycles after accept, ALUResult=0xFFFFFFFF; in_ready=0 throughout.
REQ-033 BLT SrcA=0xFFFFFFFF, SrcB=1 -> Branch=1, ALUResult=1; BGE same operands -> Branch=0, ALUResult=0.
REQ-034 SLL SrcA=0x1, SrcB=0x20 (shamt 0) with out_ready=0 for 5 cycles -> out_valid from cycle+1, ALUResult=0x1 held stable 5 cycles, IDLE after out_ready=1.
REQ-035 Operation=0110 -> ALUResult=0, Illegal=1, single-cycle latency.
REQ-036 SRL SrcB=10, reset pulsed 4 cycles after accept -> out_valid never asserts, in_ready=1 after release, next ADD 2+3 returns 5.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith/compare ops, iterative 1-bit-per-cycle shifts.
// Valid/ready command in, valid/ready result out; one command in flight at a time.
module alu_seq #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        Operation,
    input  logic [DATA_W-1:0] SrcA,
    input  logic [DATA_W-1:0] SrcB,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ALUResult,
    output logic              Branch,
    output logic              Illegal
);

    localparam logic [3:0] OpAnd = 4'b0000;
    localparam logic [3:0] OpOr  = 4'b0001;
    localparam logic [3:0] OpAdd = 4'b0010;
    localparam logic [3:0] OpSub = 4'b0011;
    localparam logic [3:0] OpXor = 4'b0100;
    localparam logic [3:0] OpBeq = 4'b1000;
    localparam logic [3:0] OpBne = 4'b1001;
    localparam logic [3:0] OpBlt = 4'b1010;
    localparam logic [3:0] OpBge = 4'b1011;
    localparam logic [3:0] OpSll = 4'b1100;
    localparam logic [3:0] OpSrl = 4'b1101;
    localparam logic [3:0] OpSlt = 4'b1110;
    localparam logic [3:0] OpSra = 4'b1111;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_t;

    state_t            r_state;
    logic [3:0]        r_op;
    logic [DATA_W-1:0] r_sh;
    logic [4:0]        r_cnt;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_result;
    logic              r_branch;
    logic              r_illegal;

    logic              w_eq;
    logic              w_lt;
    logic [4:0]        w_shamt;
    logic              w_is_shift;
    logic              w_branch;
    logic              w_illegal;
    logic [DATA_W-1:0] w_result;
    logic [DATA_W-1:0] w_sh_next;

    assign w_eq    = (SrcA == SrcB);
    assign w_lt    = ($signed(SrcA) < $signed(SrcB));
    assign w_shamt = SrcB[4:0];

    // Result for everything that completes at the accept edge; shifts by zero pass SrcA through.
    always_comb begin
        w_result   = '0;
        w_branch   = 1'b0;
        w_illegal  = 1'b0;
        w_is_shift = 1'b0;
        case (Operation)
            OpAnd: w_result = SrcA & SrcB;
            OpOr:  w_result = SrcA | SrcB;
            OpAdd: w_result = SrcA + SrcB;
            OpSub: w_result = SrcA - SrcB;
            OpXor: w_result = SrcA ^ SrcB;
            OpBeq: begin
                w_branch = w_eq;
                w_result = {{(DATA_W-1){1'b0}}, w_eq};
            end
            OpBne: begin
                w_branch = ~w_eq;
                w_result = {{(DATA_W-1){1'b0}}, ~w_eq};
            end
            OpBlt: begin
                w_branch = w_lt;
                w_result = {{(DATA_W-1){1'b0}}, w_lt};
            end
            OpBge: begin
                w_branch = ~w_lt;
                w_result = {{(DATA_W-1){1'b0}}, ~w_lt};
            end
            OpSlt: w_result = {{(DATA_W-1){1'b0}}, w_lt};
            OpSll, OpSrl, OpSra: begin
                w_is_shift = 1'b1;
                w_result   = SrcA;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_sh_next = r_sh;
        case (r_op)
            OpSll:   w_sh_next = {r_sh[DATA_W-2:0], 1'b0};
            OpSrl:   w_sh_next = {1'b0, r_sh[DATA_W-1:1]};
            OpSra:   w_sh_next = {r_sh[DATA_W-1], r_sh[DATA_W-1:1]};
            default: w_sh_next = r_sh;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_op        <= '0;
            r_sh        <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_branch    <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_op <= Operation;
                        if (w_is_shift && (w_shamt != 5'd0)) begin
                            r_sh    <= SrcA;
                            r_cnt   <= w_shamt;
                            r_state <= StShift;
                        end else begin
                            r_result    <= w_result;
                            r_branch    <= w_branch;
                            r_illegal   <= w_illegal;
                            r_out_valid <= 1'b1;
                            r_state     <= StDone;
                        end
                    end
                end
                StShift: begin
                    r_sh  <= w_sh_next;
                    r_cnt <= r_cnt - 5'd1;
                    // Last bit position moves directly into the result register.
                    if (r_cnt == 5'd1) begin
                        r_result    <= w_sh_next;
                        r_out_valid <= 1'b1;
                        r_state     <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        r_result    <= '0;
                        r_branch    <= 1'b0;
                        r_illegal   <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign in_ready  = (r_state == StIdle);
    assign out_valid = r_out_valid;
    assign ALUResult = r_result;
    assign Branch    = r_branch;
    assign Illegal   = r_illegal;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes model results, a monitor pops and compares.
// Random and directed commands, random result backpressure and a mid-operation reset.
module tb_alu_seq;

    typedef struct {
        logic [31:0] res;
        logic        br;
        logic        ill;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  Operation;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        Branch;
    logic        Illegal;

    bit   rand_ready;
    bit   force_ready;
    bit   rnd_ready;
    int   cyc;
    int   n_pass;
    int   n_tot;
    bit   prev_v;
    exp_t q[$];

    alu_seq #(.DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Operation (Operation),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUResult (ALUResult),
        .Branch    (Branch),
        .Illegal   (Illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) rnd_ready <= ($urandom_range(0, 3) != 0);
    assign out_ready = rand_ready ? rnd_ready : force_ready;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Behavioural reference: whole-word operators, latency is the shift amount for nonzero shifts.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t e;
        int   n;
        n     = int'(b[4:0]);
        e.res = 32'd0;
        e.br  = 1'b0;
        e.ill = 1'b0;
        e.lat = 0;
        e.acc = 0;
        case (op)
            4'd0:  e.res = a & b;
            4'd1:  e.res = a | b;
            4'd2:  e.res = a + b;
            4'd3:  e.res = a - b;
            4'd4:  e.res = a ^ b;
            4'd8:  e.br = (a == b);
            4'd9:  e.br = (a != b);
            4'd10: e.br = ($signed(a) < $signed(b));
            4'd11: e.br = ($signed(a) >= $signed(b));
            4'd12: begin e.res = a << n; e.lat = n; end
            4'd13: begin e.res = a >> n; e.lat = n; end
            4'd14: e.res = {31'd0, ($signed(a) < $signed(b))};
            4'd15: begin e.res = 32'($signed(a) >>> n); e.lat = n; end
            default: e.ill = 1'b1;
        endcase
        if (op inside {4'd8, 4'd9, 4'd10, 4'd11}) e.res = {31'd0, e.br};
        return e;
    endfunction

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   w;
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        in_valid  = 1'b1;
        w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            chk("issue_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        e = model(op, a, b);
        @(posedge clk);
        e.acc = cyc + 1;
        q.push_back(e);
        @(negedge clk);
        in_valid  = 1'b0;
        Operation = 4'($urandom);
        SrcA      = $urandom;
        SrcB      = $urandom;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (q.size() != 0 && w < 150) begin
            @(negedge clk);
            w++;
        end
        if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
    endtask

    // Monitor: sampled just after the falling edge so all drivers have settled.
    always @(negedge clk) begin
        #1;
        if (reset) begin
            prev_v = 1'b0;
            chk("rst_in_ready", 64'(in_ready), 64'd1);
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_outputs", {31'd0, ALUResult, Branch}, 64'd0);
            chk("rst_illegal", 64'(Illegal), 64'd0);
        end else if (out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_out_valid", 64'(out_valid), 64'd0);
            end else begin
                chk("result", 64'(ALUResult), 64'(q[0].res));
                chk("branch", 64'(Branch), 64'(q[0].br));
                chk("illegal", 64'(Illegal), 64'(q[0].ill));
                chk("in_ready_done", 64'(in_ready), 64'd0);
                if (!prev_v) chk("latency", 64'(cyc - q[0].acc), 64'(q[0].lat));
                if (out_ready) begin
                    void'(q.pop_front());
                    prev_v = 1'b0;
                end else begin
                    prev_v = 1'b1;
                end
            end
        end else begin
            prev_v = 1'b0;
            chk("idle_outputs", {31'd0, ALUResult, Branch}, 64'd0);
            chk("idle_illegal", 64'(Illegal), 64'd0);
            if (q.size() != 0) chk("in_ready_busy", 64'(in_ready), 64'd0);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        n_pass      = 0;
        n_tot       = 0;
        prev_v      = 1'b0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        Operation   = 4'd0;
        SrcA        = 32'd0;
        SrcB        = 32'd0;
        rand_ready  = 1'b0;
        force_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // First edge after release accepts; ADD overflow wraps.
        issue(4'd2, 32'h7FFF_FFFF, 32'd1);
        drain();
        issue(4'd15, 32'h8000_0000, 32'd31);
        drain();
        issue(4'd10, 32'hFFFF_FFFF, 32'd1);
        issue(4'd11, 32'hFFFF_FFFF, 32'd1);
        issue(4'd6, 32'h1234_5678, 32'h9ABC_DEF0);
        issue(4'd13, 32'hF000_000F, 32'd1);
        issue(4'd12, 32'h8000_0001, 32'd31);
        drain();

        // Shift by zero under backpressure: result held until accepted.
        force_ready = 1'b0;
        issue(4'd12, 32'h0000_0001, 32'h0000_0020);
        repeat (5) @(negedge clk);
        force_ready = 1'b1;
        drain();
        #2;
        chk("idle_after_accept", 64'(in_ready), 64'd1);
        @(negedge clk);

        // Reset mid-shift discards the operation.
        issue(4'd13, $urandom, 32'd10);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #2;
        chk("in_ready_after_abort", 64'(in_ready), 64'd1);
        @(negedge clk);
        issue(4'd2, 32'd2, 32'd3);
        drain();

        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom);
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = $urandom_range(0, 40);
                default: b = $urandom;
            endcase
            issue(op, a, b);
        end
        drain();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
